// File: rtl/dp_vec_if.sv
// Signal bundle between the vector sequencer, its host and the distance engine.
// The master side is the sequencer; the slave side is host plus engine.
interface dp_vec_if #(
    parameter int BIT = 32
);
    logic                  ld_we;
    logic [5:0]            ld_addr;
    logic signed [BIT-1:0] ld_data;
    logic                  go;
    logic                  busy;
    logic                  dv_out;
    logic signed [BIT-1:0] vec_out;
    logic                  eng_ready;
    logic                  start_out;
    logic [6:0]            index_out;
    logic                  dist_dv;
    logic [BIT+6:0]        dist_in;
    logic                  done;
    logic                  err;
    logic [6:0]            best_index;
    logic [BIT+6:0]        best_dist;

    modport master (
        input  ld_we, ld_addr, ld_data, go, eng_ready, dist_dv, dist_in,
        output busy, dv_out, vec_out, start_out, index_out, done, err,
        output best_index, best_dist
    );

    modport slave (
        output ld_we, ld_addr, ld_data, go, eng_ready, dist_dv, dist_in,
        input  busy, dv_out, vec_out, start_out, index_out, done, err,
        input  best_index, best_dist
    );
endinterface

// File: rtl/dp_vec_sequencer.sv
// Streams a host-loaded query vector to the template-distance engine, steps the
// template index 1..SIZE and keeps the minimum distance and its index.
module dp_vec_sequencer #(
    parameter int SIZE    = 100,
    parameter int DIM     = 50,
    parameter int BIT     = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic     clk,
    input  logic     rst_n,
    dp_vec_if.master bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = BIT + 7;

    localparam logic [5:0]    LAST_K = 6'(DIM - 1);
    localparam logic [6:0]    LAST_I = 7'(SIZE);
    localparam logic [6:0]    DIM_W  = 7'(DIM);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RDY,
        S_GAP,
        S_STRT,
        S_WAIT_DIST,
        S_DONE,
        S_ABORT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  go_p0;
    logic                  go_p1;
    logic [5:0]            k_q;
    logic [TW-1:0]         wcnt_q;
    logic [6:0]            idx_q;
    logic                  err_q;
    logic [DW-1:0]         best_dist_q;
    logic [6:0]            best_idx_q;
    logic signed [BIT-1:0] qbuf [DIM];

    logic busy_w;
    logic go_edge;
    logic accept;
    logic take_dist;
    logic better;
    logic wr_ok;

    assign busy_w    = state_q inside {S_SEND, S_WAIT_RDY, S_GAP, S_STRT, S_WAIT_DIST};
    assign go_edge   = go_p0 & ~go_p1;
    assign accept    = go_edge & ~busy_w;
    assign take_dist = (state_q == S_WAIT_DIST) && bus.dist_dv;
    // Strict compare so a tie keeps the earlier (lower) index.
    assign better    = bus.dist_in < best_dist_q;
    assign wr_ok     = bus.ld_we && !busy_w && ({1'b0, bus.ld_addr} < DIM_W);

    // go stage p0/p1: registered level, rising edge taken between the two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_p0 <= 1'b0;
            go_p1 <= 1'b0;
        end else begin
            go_p0 <= bus.go;
            go_p1 <= go_p0;
        end
    end

    // Query buffer is frozen while a search runs.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            qbuf[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ABORT: begin
                state_d = accept ? S_SEND : S_IDLE;
            end
            S_SEND: begin
                if (k_q == LAST_K) begin
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (bus.eng_ready) begin
                    state_d = S_GAP;
                end else if (wcnt_q == TO_MAX) begin
                    state_d = S_ABORT;
                end
            end
            S_GAP: begin
                state_d = S_STRT;
            end
            S_STRT: begin
                state_d = S_WAIT_DIST;
            end
            S_WAIT_DIST: begin
                if (bus.dist_dv) begin
                    state_d = (idx_q == LAST_I) ? S_DONE : S_GAP;
                end else if (wcnt_q == TO_MAX) begin
                    state_d = S_ABORT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Word counter for SEND; wait counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= 6'd0;
            wcnt_q <= '0;
        end else begin
            k_q    <= (state_q == S_SEND) ? k_q + 6'd1 : 6'd0;
            wcnt_q <= (state_d != state_q) ? '0 : wcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 7'd0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= 7'd0;
            end else if (state_q == S_SEND && state_d == S_WAIT_RDY) begin
                idx_q <= 7'd1;
            end else if (take_dist && idx_q != LAST_I) begin
                idx_q <= idx_q + 7'd1;
            end

            if (accept) begin
                err_q <= 1'b0;
            end else if (state_d == S_ABORT) begin
                err_q <= 1'b1;
            end
        end
    end

    // Result capture: preset to all-ones on accept, then running minimum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_dist_q <= '0;
            best_idx_q  <= 7'd0;
        end else if (accept) begin
            best_dist_q <= '1;
            best_idx_q  <= 7'd0;
        end else if (take_dist && better) begin
            best_dist_q <= bus.dist_in;
            best_idx_q  <= idx_q;
        end
    end

    assign bus.busy       = busy_w;
    assign bus.dv_out     = (state_q == S_SEND);
    assign bus.vec_out    = (state_q == S_SEND) ? qbuf[k_q] : '0;
    assign bus.start_out  = (state_q == S_STRT);
    assign bus.index_out  = idx_q;
    assign bus.done       = (state_q == S_DONE) || (state_q == S_ABORT);
    assign bus.err        = err_q;
    assign bus.best_index = best_idx_q;
    assign bus.best_dist  = best_dist_q;

endmodule

// File: doc/dp_vec_sequencer.md
Name: dp_vec_sequencer

Overview:
- Drives the input side of the template-distance engine: the vector stream, the template start/index pulses and the result capture.
- Holds one DIM-word query vector loaded by the host, streams it to the engine, then steps the template index through 1..SIZE.
- Collects one distance per index and reports the minimum distance and its index.
- Sits between the feature-extraction front end and the distance engine.

Parameters:
- SIZE, 100, number of templates; indices 1..SIZE.
- DIM, 50, words per vector.
- BIT, 32, signed word width.
- TIMEOUT, 1023, maximum cycles to wait for a distance result before aborting.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_we  in  1  host write strobe for the query buffer.
- ld_addr  in  6  host word address, valid range 0..DIM-1.
- ld_data  in  BIT  host word, signed.
- go  in  1  level; a rising edge starts a search.
- busy  out  1  high from go accept until done.
- dv_out  out  1  to engine dv_in.
- vec_out  out  BIT  to engine vec_in.
- eng_ready  in  1  engine "vector captured" pulse.
- start_out  out  1  to engine start.
- index_out  out  7  to engine index.
- dist_dv  in  1  engine result-valid pulse, 1 cycle.
- dist_in  in  BIT+7  engine distance, unsigned.
- done  out  1  1-cycle pulse at end of search.
- err  out  1  sticky timeout flag, cleared by the next accepted go.
- best_index  out  7  index of the minimum distance.
- best_dist  out  BIT+7  minimum distance.

Behaviour:
- Reset values: all outputs 0, including best_dist, best_index, err and busy. Reset is asynchronous and aborts any search in progress. The query buffer contents are undefined after reset.
- Load:
  - ld_we writes ld_data to buf[ld_addr] when busy=0.
  - ld_addr >= DIM is ignored.
  - ld_we while busy=1 is ignored, so the buffer stays stable during a search.
- Start: go is registered; its rising edge while busy=0 enters SEND on the next cycle. busy rises the same cycle, err clears, and best_dist is preset to all-ones. A go edge while busy=1 is ignored.
- IDLE -> SEND:
  - dv_out=1 for exactly DIM consecutive cycles.
  - vec_out=buf[k] on cycle k, k=0..DIM-1.
  - dv_out was low for at least 1 cycle before, since it is 0 in IDLE.
- SEND -> WAIT_RDY:
  - dv_out=0, vec_out=0.
  - Wait for eng_ready, or TIMEOUT cycles -> ABORT.
  - index counter i=1.
- WAIT_RDY -> GAP: start_out=0 for 1 cycle. This guarantees a rising edge at the engine.
- GAP -> STRT: start_out=1, index_out=i. index_out holds i from STRT through WAIT_DIST.
- STRT -> WAIT_DIST:
  - start_out returns to 0 on entry to WAIT_DIST, giving a 1-cycle high pulse.
  - A cycle counter starts at 0 on entry.
  - On a dist_dv pulse: if dist_in < best_dist (strict), load best_dist=dist_in and best_index=i. On a tie the earlier (lower) index wins.
  - If i==SIZE go to DONE, else i<=i+1 and go to GAP.
  - If the counter reaches TIMEOUT with no dist_dv, go to ABORT.
- dist_dv outside WAIT_DIST is ignored.
- DONE: done=1 for 1 cycle, busy=0, then IDLE. best_* hold until the next accepted go.
- ABORT: err=1, done=1 for 1 cycle, busy=0, then IDLE. best_* reflect the results captured so far; best_dist is all-ones if none were captured.
- Per-index overhead: GAP+STRT+engine latency. The engine returns dist about 2*DIM+2 cycles after the start edge, so TIMEOUT must exceed 2*DIM+4.
- Arithmetic: compare is unsigned over BIT+7 bits. The index counter is 7 bits; SIZE <= 127 is required.

Test Plan:
- Load buf[k]=k+1 (DIM=50), pulse go:
  - dv_out is high exactly 50 cycles with vec_out 1..50 in order.
  - busy=1.
  - With an engine behavioural model returning dist=|100-i|, best_index=100, best_dist=0, done pulses once, err=0.
- Model returns dist=500 for all i -> best_index=1 (tie keeps lowest), best_dist=500.
- Check start_out/index_out:
  - There are exactly SIZE=100 start_out rising edges.
  - index_out=1..100, each start_out high exactly 1 cycle preceded by a low cycle.
- Model withholds dist_dv at i=7:
  - after TIMEOUT=1023 cycles, err=1 and done=1.
  - best_* hold the minimum of i=1..6.
  - The next go clears err.
- Assert rst_n low during SEND at cycle 20 -> dv_out, busy, start_out go to 0 immediately (asynchronously). After release, the block is in IDLE, and a new go streams the full vector.
- ld_we to addr 3 while busy -> buffer unchanged. A second go edge while busy -> ignored; only one done pulse occurs. ld_addr=60 -> no write.
